// File: rtl/shift_serializer_ctrl.sv
// Load/shift sequencer for an external shift register: one load pulse, then SIZE
// shift pulses spaced DIV clocks apart, with the register MSB presented as a serial stream.
module shift_serializer_ctrl #(
  parameter int SIZE = 9,
  parameter int DIV  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic msb_in,
  output logic ldEN,
  output logic shEN,
  output logic serial_out,
  output logic serial_valid,
  output logic busy,
  output logic done
);
  localparam int BW = $clog2(SIZE);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(SIZE - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} stateT;

  stateT          state, nState;
  logic [BW-1:0]  bitCnt, nBit;
  logic [DW-1:0]  divCnt, nDiv;

  always_comb begin
    nState = state;
    nBit   = bitCnt;
    nDiv   = divCnt;
    case (state)
      IDLE: if (start) begin
        nState = LOAD;
        nBit   = '0;
        nDiv   = '0;
      end
      LOAD: nState = SHIFT;
      SHIFT: begin
        if (divCnt == DIV_LAST) begin
          nDiv = '0;
          if (bitCnt == BIT_LAST) nState = DONE;
          else                    nBit   = bitCnt + BW'(1);
        end else begin
          nDiv = divCnt + DW'(1);
        end
      end
      DONE: begin
        if (start) begin
          nState = LOAD;
          nBit   = '0;
          nDiv   = '0;
        end else begin
          nState = IDLE;
        end
      end
      default: nState = IDLE;
    endcase
    // The shEN already issued this cycle is a registered output, so it still lands.
    if (abort) begin
      nState = IDLE;
      nBit   = '0;
      nDiv   = '0;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      bitCnt       <= '0;
      divCnt       <= '0;
      ldEN         <= 1'b0;
      shEN         <= 1'b0;
      serial_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= nState;
      bitCnt       <= nBit;
      divCnt       <= nDiv;
      ldEN         <= (nState == LOAD);
      shEN         <= (nState == SHIFT) && (nDiv == DIV_LAST);
      serial_valid <= (nState == SHIFT);
      busy         <= (nState == LOAD) || (nState == SHIFT);
      done         <= (nState == DONE);
    end
  end

  assign serial_out = serial_valid & msb_in;
endmodule

// File: tb/tb_shift_serializer_ctrl.sv
// Bench for shift_serializer_ctrl: two instances (DIV=4 and DIV=1) each driving a modelled
// shift register, checked every cycle against a frame-position reference model.
module tb_shift_serializer_ctrl;
  localparam int SIZE = 9;
  localparam int DIV0 = 4;
  localparam int DIV1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [SIZE-1:0] parIn = '0;

  logic msbIn[2], ldEN[2], shEN[2], serOut[2], serVld[2], busy[2], done[2];
  logic [SIZE-1:0] sreg[2] = '{default: '0};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  shift_serializer_ctrl #(.SIZE(SIZE), .DIV(DIV0)) u0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .msb_in(msbIn[0]),
    .ldEN(ldEN[0]), .shEN(shEN[0]), .serial_out(serOut[0]),
    .serial_valid(serVld[0]), .busy(busy[0]), .done(done[0]));

  shift_serializer_ctrl #(.SIZE(SIZE), .DIV(DIV1)) u1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .msb_in(msbIn[1]),
    .ldEN(ldEN[1]), .shEN(shEN[1]), .serial_out(serOut[1]),
    .serial_valid(serVld[1]), .busy(busy[1]), .done(done[1]));

  assign msbIn[0] = sreg[0][SIZE-1];
  assign msbIn[1] = sreg[1][SIZE-1];

  // Upstream shift register, driven by whatever enables the DUT actually produces.
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (ldEN[i])      sreg[i] <= parIn;
      else if (shEN[i]) sreg[i] <= sreg[i] << 1;

  // Reference: position within a frame (-1 idle, 0 load, 1..SIZE*DIV shifting, last = done).
  function automatic int dv(int i);
    return (i == 0) ? DIV0 : DIV1;
  endfunction
  function automatic int lastPos(int i);
    return SIZE * dv(i) + 1;
  endfunction

  int pos[2] = '{-1, -1};
  logic [SIZE-1:0] word[2] = '{default: '0};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos[0] <= -1;
      pos[1] <= -1;
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (pos[i] == 0) word[i] <= parIn;
        if (abort)                                     pos[i] <= -1;
        else if (pos[i] == -1 || pos[i] == lastPos(i)) pos[i] <= start ? 0 : -1;
        else                                           pos[i] <= pos[i] + 1;
      end
    end
  end

  // {ldEN, shEN, serial_out, serial_valid, busy, done}
  function automatic logic [5:0] expOut(int i, int p, logic [SIZE-1:0] w);
    logic ld, sh, so, sv, bz, dn;
    ld = (p == 0);
    sv = (p >= 1) && (p <= lastPos(i) - 1);
    sh = 1'b0;
    so = 1'b0;
    if (sv) begin
      sh = ((p % dv(i)) == 0);
      so = w[SIZE - 1 - (p - 1) / dv(i)];
    end
    bz = (p >= 0) && (p < lastPos(i));
    dn = (p == lastPos(i));
    return {ld, sh, so, sv, bz, dn};
  endfunction

  task automatic cmpBit(string nm, int i, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[u%0d] cyc=%0d got=%b want=%b", nm, i, cyc, act, exp);
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  // Event monitor state, used by the hand-computed timing checks.
  int ldC[2] = '{0, 0};
  int doneC[2] = '{0, 0};
  int doneCnt[2] = '{0, 0};
  int shCnt[2] = '{0, 0};
  int firstSh[2] = '{-1, -1};
  int lastSh[2] = '{-1, -1};
  logic [SIZE-1:0] capWord = '0;
  bit b2b = 1'b0;
  int ldQ[$];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [5:0] e;
      e = expOut(i, pos[i], word[i]);
      cmpBit("ldEN", i, ldEN[i], e[5]);
      cmpBit("shEN", i, shEN[i], e[4]);
      cmpBit("serial_out", i, serOut[i], e[3]);
      cmpBit("serial_valid", i, serVld[i], e[2]);
      cmpBit("busy", i, busy[i], e[1]);
      cmpBit("done", i, done[i], e[0]);
      if (rst && pos[i] == lastPos(i)) cmpBit("regEmpty", i, sreg[i] == '0, 1'b1);

      if (ldEN[i]) begin
        ldC[i] = cyc;
        shCnt[i] = 0;
        firstSh[i] = -1;
        lastSh[i] = -1;
        if (i == 0) capWord = '0;
        if (i == 0 && b2b) ldQ.push_back(cyc);
      end
      if (shEN[i]) begin
        shCnt[i]++;
        if (firstSh[i] < 0) firstSh[i] = cyc;
        lastSh[i] = cyc;
      end
      if (done[i]) begin
        doneC[i] = cyc;
        doneCnt[i]++;
      end
      if (i == 0 && serVld[0] && ((cyc - ldC[0] - 1) % DIV0) == 1)
        capWord = {capWord[SIZE-2:0], serOut[0]};
    end
  end

  task automatic chkAllZero(string nm);
    for (int i = 0; i < 2; i++) begin
      cmpBit({nm, ".ldEN"}, i, ldEN[i], 1'b0);
      cmpBit({nm, ".shEN"}, i, shEN[i], 1'b0);
      cmpBit({nm, ".serial_out"}, i, serOut[i], 1'b0);
      cmpBit({nm, ".serial_valid"}, i, serVld[i], 1'b0);
      cmpBit({nm, ".busy"}, i, busy[i], 1'b0);
      cmpBit({nm, ".done"}, i, done[i], 1'b0);
    end
  endtask

  initial begin
    int d0, d1;
    // Reset held with start asserted: everything quiet.
    rst = 1'b0;
    start = 1'b1;
    parIn = 9'h165;
    repeat (3) @(negedge clk);
    chkAllZero("rstHold");
    rst = 1'b1;
    @(negedge clk);
    chk("ldAfterRst", int'(ldEN[0]), 1);
    start = 1'b0;
    repeat (42) @(negedge clk);

    // Single frame, 9'h165: literal timing relative to the load cycle.
    chk("u0.doneOffset", doneC[0] - ldC[0], 37);
    chk("u0.shCount", shCnt[0], 9);
    chk("u0.firstShOffset", firstSh[0] - ldC[0], 4);
    chk("u0.lastShOffset", lastSh[0] - ldC[0], 36);
    chk("u0.serialWord", int'(capWord), 'h165);
    chk("u0.regAfter", int'(sreg[0]), 0);
    chk("u1.doneOffset", doneC[1] - ldC[1], 10);
    chk("u1.shCount", shCnt[1], 9);
    chk("u1.firstShOffset", firstSh[1] - ldC[1], 1);
    chk("u1.shSpan", lastSh[1] - firstSh[1], 8);
    chk("u1.regAfter", int'(sreg[1]), 0);

    // Abort in cycle 12 of a frame.
    parIn = 9'h0B3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = doneCnt[0];
    repeat (11) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.busy", int'(busy[0]), 0);
    repeat (45) @(negedge clk);
    chk("abort.noDone", doneCnt[0], d0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (42) @(negedge clk);
    chk("abort.nextFrameDone", doneCnt[0], d0 + 1);

    // Asynchronous reset in cycle 20.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    chk("midFrame.busy", int'(busy[0]), 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chkAllZero("asyncRst");
    @(negedge clk);
    rst = 1'b1;
    d0 = doneCnt[0];
    d1 = doneCnt[1];
    repeat (50) @(negedge clk);
    chk("rst.noDone0", doneCnt[0], d0);
    chk("rst.noDone1", doneCnt[1], d1);

    // Back-to-back frames with start held high.
    b2b = 1'b1;
    start = 1'b1;
    for (int c = 0; c < 120; c++) begin
      parIn = SIZE'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    b2b = 1'b0;
    repeat (45) @(negedge clk);
    chk("b2b.loads", int'(ldQ.size() >= 3), 1);
    if (ldQ.size() >= 3) begin
      chk("b2b.period1", ldQ[1] - ldQ[0], 38);
      chk("b2b.period2", ldQ[2] - ldQ[1], 38);
    end

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      start = ($urandom_range(7) == 0);
      abort = ($urandom_range(63) == 0);
      parIn = SIZE'($urandom);
      rst = ($urandom_range(499) != 0);
      @(negedge clk);
    end
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (45) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_serializer_ctrl.md
# shift_serializer_ctrl

Control FSM that drives the load/shift enables of the upstream `ShiftRegister` and turns its parallel word into a timed serial bit stream. On a `start` request it issues one load pulse, then SIZE shift pulses spaced DIV clocks apart. It presents the register MSB as `serial_out` with a valid strobe, and reports completion with a one-cycle `done`. The block sits directly beside the shift register: its `ldEN`/`shEN` outputs wire to the register's enables, and the register's `parallelOUT[SIZE-1]` wires back into `msb_in`.

## Interface

- SIZE, 9: word width; must match the shift register's SIZE; ≥ 2.
- DIV, 4: clock cycles per serial bit; ≥ 1.

- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  transfer request; sampled only in IDLE or DONE.
- abort  input  1  synchronous cancel; returns to IDLE without `done`.
- msb_in  input  1  `parallelOUT[SIZE-1]` of the shift register.
- ldEN  output  1  load enable to the shift register.
- shEN  output  1  shift enable to the shift register.
- serial_out  output  1  current serial bit; MSB first.
- serial_valid  output  1  high while `serial_out` carries a payload bit.
- busy  output  1  high in LOAD and SHIFT.
- done  output  1  one-cycle completion pulse.

## Operation

- **States:** IDLE, LOAD, SHIFT, DONE. Use a 2-bit state register.
- **Counters:**
  - `bit_cnt` is $clog2(SIZE) bits and counts 0..SIZE-1.
  - `div_cnt` is max(1, $clog2(DIV)) bits and counts 0..DIV-1.
  - Both clear on reset and on entry to LOAD.
- **IDLE:** all outputs 0. `start`=1 moves to LOAD; otherwise stay.
- **LOAD:** `ldEN`=1 and `busy`=1 for exactly one cycle. Next state is SHIFT unconditionally.
- **SHIFT:**
  - `busy`=1, `serial_valid`=1, `serial_out`=`msb_in`.
  - `div_cnt` increments each cycle.
  - When `div_cnt`==DIV-1, `shEN`=1 for that cycle and `div_cnt` wraps to 0.
  - If `bit_cnt`==SIZE-1 at that moment, go to DONE. Otherwise `bit_cnt` increments.
  - With DIV=1, `shEN` is high on every SHIFT cycle.
- **DONE:** `done`=1 for one cycle; `busy`=0, `serial_valid`=0.
  - `start`=1 here goes directly to LOAD, giving back-to-back frames.
  - Otherwise go to IDLE.
- **Enables:** `ldEN` and `shEN` are decoded from state and counters and are never high in the same cycle.
- **Exactly one shift per bit:** the register receives exactly SIZE shift pulses per frame, so it holds 0 after the frame.
- **abort:** takes priority over every transition except reset. `abort`=1 in any state gives next state IDLE with counters cleared and no `done` pulse. If `abort` is high in the same cycle as `shEN`, that shift still reaches the register.
- **start outside IDLE/DONE:** `start` in LOAD or SHIFT is ignored; it is not queued.
- **Reset:** `rst`=0 asynchronously forces IDLE and clears both counters. All outputs read 0 while reset is held: `ldEN`, `shEN`, `serial_out`, `serial_valid`, `busy`, `done`.
- **Reset mid-frame:** the frame is lost. No `done` is issued after release.

## Timing

- **Start-to-load:** with `start` sampled high at edge 0:
  - LOAD occupies cycle 1.
  - The register loads at edge 2.
- **Shift phase:** SHIFT occupies cycles 2 through 1+SIZE·DIV. Bit k (k=0 is the MSB) is valid on cycles 2+k·DIV through 1+(k+1)·DIV.
- **Completion:** `done` is high in cycle 2+SIZE·DIV. For the defaults (SIZE=9, DIV=4) this is cycle 38.
- **Back-to-back frames:** when `start` is high during DONE, the next LOAD follows immediately, for a period of 2+SIZE·DIV cycles per frame.
- **Reset release:** the first `start` is accepted on the first rising edge with `rst`=1.

## Test plan

- **Reset values:** hold `rst`=0 for 3 cycles with `start`=1 → all outputs 0. Release `rst` → LOAD follows on the next edge.
- **Single frame:**
  - Stimulus: defaults, parallelIN=9'h165, single `start` pulse.
  - `ldEN` is high in cycle 1 only.
  - `serial_out` reads 1,0,1,1,0,0,1,0,1, each bit held for 4 cycles.
  - `shEN` pulses at cycles 5, 9, …, 37 (9 pulses).
  - `done` is high in cycle 38 only.
  - Register reads 0 afterwards.
- **DIV=1:** SIZE=9, DIV=1, parallelIN=9'h1FF → `shEN` is high for cycles 2–10 continuously and `done` is high in cycle 11.
- **Back-to-back:** hold `start` high continuously → `ldEN` pulses at cycles 1, 39, 77. `busy` drops only during the DONE cycles (38, 76, …).
- **Abort:** assert `abort` in cycle 12 → IDLE at cycle 13, `busy`=0, and `done` never asserts. A new `start` then produces a full 9-bit frame.
- **Async reset mid-frame:** drive `rst` low between edges in cycle 20 → outputs go to 0 immediately, without waiting for a clock edge. After release, `done` is not issued until a new `start` is given.
